// File: rtl/color_band_pkg.sv
// Shared definitions for the colour-band sequencer: FSM state type,
// a width helper and the default 640-pixel / 144-offset geometry.
package color_band_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_VISIBLE_W = 640;
  localparam int DEF_N_BANDS   = 8;
  localparam int DEF_BAND_W    = DEF_VISIBLE_W / DEF_N_BANDS;
  localparam int DEF_H_START   = 144;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/band_pixel_counter.sv
// Pixel position inside the current band: CE-gated modulo-BAND_W counter
// with synchronous clear and a terminal-count flag on the last pixel.
module band_pixel_counter
  import color_band_pkg::*;
#(
  parameter int BAND_W = DEF_BAND_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CNT_W = clog2(BAND_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAND_W - 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment; the count wraps to 0 after the last pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc) begin
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_tc = (r_cnt == LAST_CNT);

endmodule

// File: rtl/color_band_sequencer.sv
// Horizontal colour-band sequencer: registered band index, in-region flag
// and band-entry pulse, aligned with the pixel address.
// Optional frame rotation of the band index: define COLOR_BAND_ROTATE_EN.
module color_band_sequencer
  import color_band_pkg::*;
#(
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int N_BANDS = DEF_N_BANDS,
  parameter  int BAND_W  = DEF_BAND_W,
  parameter  int H_START = DEF_H_START,
  localparam int IDX_W   = clog2(N_BANDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic [ADDR_W-1:0] A,
`ifdef COLOR_BAND_ROTATE_EN
  input  logic              FRAME_TICK,
`endif
  output logic [IDX_W-1:0]  Q,
  output logic              ACTIVE,
  output logic              EDGE
);

  localparam logic [ADDR_W-1:0] RESYNC_A = ADDR_W'(H_START - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BANDS - 1);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [IDX_W-1:0] r_q, w_q_next;
  logic             r_active, w_active_next;
  logic             r_edge, w_edge_next;
  logic             w_resync;
  logic             w_tc;

  // The pixel just before band 0 restarts the line from any state.
  assign w_resync = CE && (A == RESYNC_A);

  band_pixel_counter #(
    .BAND_W (BAND_W)
  ) u_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_ce  (CE),
    .i_clr (w_resync),
    .i_inc (r_state == RUN),
    .o_tc  (w_tc)
  );

`ifdef COLOR_BAND_ROTATE_EN
  logic [IDX_W-1:0] r_rot, r_rot_l;

  // Frame rotation advances on every tick, independent of the pixel enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rot <= '0;
    end else if (FRAME_TICK) begin
      r_rot <= (r_rot == LAST_IDX) ? '0 : r_rot + IDX_W'(1);
    end
  end

  // Rotation is frozen per line so a mid-line tick only affects the next line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rot_l <= '0;
    end else if (w_resync) begin
      r_rot_l <= r_rot;
    end
  end

  function automatic logic [IDX_W-1:0] band_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] rot);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + {1'b0, rot};
    if (sum >= (IDX_W+1)'(N_BANDS)) begin
      sum = sum - (IDX_W+1)'(N_BANDS);
    end
    return sum[IDX_W-1:0];
  endfunction
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, band index and next output values; everything holds when CE=0.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_edge_next   = r_edge;
    w_active_next = r_active;
    w_q_next      = r_q;
    if (CE) begin
      w_edge_next = 1'b0;
      if (w_resync) begin
        w_state_next = RUN;
        w_idx_next   = '0;
        w_edge_next  = 1'b1;
      end else if ((r_state == RUN) && w_tc) begin
        if (r_idx == LAST_IDX) begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next  = r_idx + IDX_W'(1);
          w_edge_next = 1'b1;
        end
      end
      w_active_next = (w_state_next == RUN);
`ifdef COLOR_BAND_ROTATE_EN
      w_q_next = w_active_next ? band_of(w_idx_next, w_resync ? r_rot : r_rot_l) : '0;
`else
      w_q_next = w_active_next ? w_idx_next : '0;
`endif
    end
  end

  // Band index and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx    <= '0;
      r_q      <= '0;
      r_active <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_idx    <= w_idx_next;
      r_q      <= w_q_next;
      r_active <= w_active_next;
      r_edge   <= w_edge_next;
    end
  end

  assign Q      = r_q;
  assign ACTIVE = r_active;
  assign EDGE   = r_edge;

endmodule

// File: tb/tb_color_band_sequencer.sv
// Randomised self-checking bench for color_band_sequencer against a
// pixel-position model (default geometry plus a tiny 3x4 instance).
module tb_color_band_sequencer;
  import color_band_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int N  = DEF_N_BANDS;
  localparam int BW = DEF_BAND_W;
  localparam int HS = DEF_H_START;
  localparam int IW = clog2(N);
`ifdef COLOR_BAND_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, ce = 1'b0, tick = 1'b0;
  logic [AW-1:0] a = '0;
  logic [IW-1:0] q;
  logic          act, edg;

  logic          s_rst = 1'b1, s_ce = 1'b0;
  logic [3:0]    s_a = '0;
  logic [1:0]    s_q;
  logic          s_act, s_edg;
`ifdef COLOR_BAND_ROTATE_EN
  logic          s_tick = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: pixel position within the banded line (-1 when outside it).
  int m_pos = -1;
  int m_rot = 0;
  int m_rotl = 0;

  color_band_sequencer dut (
    .CLK(clk), .RST(rst), .CE(ce), .A(a),
`ifdef COLOR_BAND_ROTATE_EN
    .FRAME_TICK(tick),
`endif
    .Q(q), .ACTIVE(act), .EDGE(edg)
  );

  color_band_sequencer #(.ADDR_W(4), .N_BANDS(3), .BAND_W(4), .H_START(1)) dut_s (
    .CLK(clk), .RST(s_rst), .CE(s_ce), .A(s_a),
`ifdef COLOR_BAND_ROTATE_EN
    .FRAME_TICK(s_tick),
`endif
    .Q(s_q), .ACTIVE(s_act), .EDGE(s_edg)
  );

  function automatic logic [IW-1:0] exp_q();
    if (m_pos < 0) return '0;
    return IW'((m_pos / BW + (ROT_EN ? m_rotl : 0)) % N);
  endfunction
  function automatic logic exp_act();
    return m_pos >= 0;
  endfunction
  function automatic logic exp_edge();
    return (m_pos >= 0) && (m_pos % BW == 0);
  endfunction

  // One clock of stimulus on the main instance; starts and ends at a negedge.
  task automatic step(input logic c, input int addr, input logic t, input logic r);
    int old_rot;
    ce = c; a = addr[AW-1:0]; tick = t; rst = r;
    @(posedge clk);
    if (r) begin
      m_pos = -1; m_rot = 0; m_rotl = 0;
    end else begin
      old_rot = m_rot;
      if (t) m_rot = (m_rot + 1) % N;
      if (c) begin
        if (addr == HS - 1) begin
          m_pos = 0; m_rotl = old_rot;
        end else if (m_pos >= 0) begin
          m_pos++;
          if (m_pos >= N * BW) m_pos = -1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(1, HS - 1, 0, 1);
    checks++;
    if (q !== '0 || act !== 1'b0 || edg !== 1'b0) begin
      errors++;
      $display("FAIL reset Q=%0d ACTIVE=%0b EDGE=%0b required 0/0/0", q, act, edg);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_sweep();
    int edges = 0;
    for (int i = 0; i < 800; i++) begin
      step(1, i, 0, 0);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL sweep A=%0d Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 i + 1, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
      if (edg) begin
        edges++;
        checks++;
        if ((i + 1 - HS) % BW != 0 || i + 1 < HS) begin
          errors++;
          $display("FAIL sweep_edge_pos at A=%0d required band start", i + 1);
        end
      end
      if (i + 1 == HS + N * BW) begin
        checks++;
        if (act !== 1'b0) begin
          errors++;
          $display("FAIL sweep_active_end A=%0d ACTIVE=%0b required 0", i + 1, act);
        end
      end
    end
    checks++;
    if (edges != N) begin
      errors++;
      $display("FAIL sweep_edge_count got %0d required %0d", edges, N);
    end
  endtask

  task automatic test_ce_toggle();
    int addr = 0;
    int edges = 0;
    for (int i = 0; i < 1600; i++) begin
      logic c;
      c = (i % 2 == 0);
      step(c, addr, 0, 0);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL ce_toggle cyc=%0d A=%0d CE=%0b Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 i, addr, c, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
      if (c) begin
        if (edg) edges++;
        addr++;
      end
    end
    checks++;
    if (edges != N) begin
      errors++;
      $display("FAIL ce_toggle_edge_count got %0d required %0d", edges, N);
    end
  endtask

  task automatic test_resync_midline();
    int edges = 0;
    for (int i = 0; i <= 400; i++) step(1, i, 0, 0);
    step(1, HS - 1, 0, 0);
    checks++;
    if (edg !== 1'b1 || q !== exp_q() || act !== 1'b1) begin
      errors++;
      $display("FAIL resync_start Q=%0d/%0d ACTIVE=%0b/1 EDGE=%0b/1", q, exp_q(), act, edg);
    end
    if (edg) edges++;
    for (int i = HS; i < 900; i++) begin
      step(1, i, 0, 0);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL resync A=%0d Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 i + 1, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
      if (edg) edges++;
    end
    checks++;
    if (edges != N) begin
      errors++;
      $display("FAIL resync_edge_count got %0d required %0d", edges, N);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i <= 560; i++) step(1, i, 0, 0);
    checks++;
    if (q !== 3'd5) begin
      errors++;
      $display("FAIL midrun_band Q=%0d required 5", q);
    end
    step(1, 561, 0, 1);
    checks++;
    if (q !== '0 || act !== 1'b0 || edg !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset Q=%0d ACTIVE=%0b EDGE=%0b required 0/0/0", q, act, edg);
    end
    for (int i = 562; i < 1024 + HS + 20; i++) begin
      step(1, i % 1024, 0, 0);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL midrun_idle A=%0d Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 (i + 1) % 1024, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
    end
  endtask

  task automatic test_random();
    int addr = 0;
    for (int i = 0; i < 4000; i++) begin
      logic c, t, r;
      c = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 799) == 0);
      if (c) begin
        if ($urandom_range(0, 99) == 0) addr = $urandom_range(0, 1023);
        else addr = (addr + 1) % 800;
      end
      step(c, addr, t, r);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL random cyc=%0d A=%0d CE=%0b RST=%0b Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 i, addr, c, r, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
    end
  endtask

`ifdef COLOR_BAND_ROTATE_EN
  task automatic test_rotate();
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
    for (int i = 0; i < 800; i++) begin
      step(1, i, (i == 300), 0);
      checks++;
      if (q !== exp_q() || act !== exp_act() || edg !== exp_edge()) begin
        errors++;
        $display("FAIL rotate A=%0d Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 i + 1, q, exp_q(), act, exp_act(), edg, exp_edge());
      end
      if (i + 1 == HS || i + 1 == HS + (N - 1) * BW) begin
        checks++;
        if (q !== ((i + 1 == HS) ? 3'd3 : 3'd2)) begin
          errors++;
          $display("FAIL rotate_band A=%0d Q=%0d", i + 1, q);
        end
      end
    end
  endtask
`endif

  task automatic test_small();
    s_rst = 1'b1; s_ce = 1'b1; s_a = 4'd0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_q !== 2'd0 || s_act !== 1'b0 || s_edg !== 1'b0) begin
      errors++;
      $display("FAIL small_reset Q=%0d ACTIVE=%0b EDGE=%0b required 0/0/0", s_q, s_act, s_edg);
    end
    s_rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      int p;
      logic       e_act, e_edg;
      logic [1:0] e_q;
      s_a = 4'(i);
      @(posedge clk); @(negedge clk);
      p = i + 1;
      e_act = (p >= 1) && (p <= 12);
      e_q   = e_act ? 2'((p - 1) / 4) : 2'd0;
      e_edg = e_act && ((p - 1) % 4 == 0);
      checks++;
      if (s_q !== e_q || s_act !== e_act || s_edg !== e_edg) begin
        errors++;
        $display("FAIL small A=%0d Q=%0d/%0d ACTIVE=%0b/%0b EDGE=%0b/%0b",
                 p, s_q, e_q, s_act, e_act, s_edg, e_edg);
      end
    end
    s_ce = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sweep();
    test_ce_toggle();
    test_resync_midline();
    test_reset_midrun();
    test_random();
`ifdef COLOR_BAND_ROTATE_EN
    test_rotate();
`endif
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
